// File: rtl/pcie_tlp_pkg.sv
// Shared TLP stream definitions for the PCIe TX completion path.
// Widths, arbiter state encoding and the per-beat bundle.
package pcie_tlp_pkg;

    localparam int TLP_DATA_W = 256;
    localparam int TLP_STRB_W = TLP_DATA_W / 32;
    localparam int TLP_HDR_W  = 128;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [TLP_DATA_W-1:0] data;
        logic [TLP_STRB_W-1:0] strb;
        logic [TLP_HDR_W-1:0]  hdr;
        logic                  sop;
        logic                  eop;
    } tlp_beat_t;

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational round-robin picker: first request at or above ptr,
// wrapping modulo PORTS. Returns one-hot grant, index and any-flag.
module rr_arb_pick #(
    parameter int PORTS = 3,
    parameter int IW    = $clog2(PORTS)
) (
    input  logic [PORTS-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [PORTS-1:0] gnt_oh,
    output logic [IW-1:0]    gnt_idx,
    output logic             gnt_any
);

    logic [IW:0] pos;

    // Walk ports starting at ptr; the first requester wins
    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        pos     = '0;
        for (int k = 0; k < PORTS; k++) begin
            pos = {1'b0, ptr} + (IW+1)'(k);
            if (pos >= (IW+1)'(PORTS)) begin
                pos = pos - (IW+1)'(PORTS);
            end
            if (!gnt_any && req[pos[IW-1:0]]) begin
                gnt_any              = 1'b1;
                gnt_idx              = pos[IW-1:0];
                gnt_oh[pos[IW-1:0]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pcie_cpl_tlp_arb.sv
// Packet-locked round-robin arbiter feeding the completion TLP egress.
// One source owns the egress from SOP to EOP; no storage is added.
module pcie_cpl_tlp_arb
    import pcie_tlp_pkg::*;
#(
    parameter int PORTS      = 3,
    parameter int DATA_WIDTH = TLP_DATA_W,
    parameter int STRB_WIDTH = TLP_STRB_W,
    parameter int HDR_WIDTH  = TLP_HDR_W,
    localparam int IW        = $clog2(PORTS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PORTS*DATA_WIDTH-1:0] s_tlp_data,
    input  logic [PORTS*STRB_WIDTH-1:0] s_tlp_strb,
    input  logic [PORTS*HDR_WIDTH-1:0]  s_tlp_hdr,
    input  logic [PORTS-1:0]            s_tlp_valid,
    input  logic [PORTS-1:0]            s_tlp_sop,
    input  logic [PORTS-1:0]            s_tlp_eop,
    output logic [PORTS-1:0]            s_tlp_ready,
    output logic [DATA_WIDTH-1:0]       tx_cpl_tlp_data,
    output logic [STRB_WIDTH-1:0]       tx_cpl_tlp_strb,
    output logic [HDR_WIDTH-1:0]        tx_cpl_tlp_hdr,
    output logic                        tx_cpl_tlp_valid,
    output logic                        tx_cpl_tlp_sop,
    output logic                        tx_cpl_tlp_eop,
    input  logic                        tx_cpl_tlp_ready,
    output logic [IW-1:0]               grant_idx,
    output logic                        proto_err
);

    if (PORTS < 2 || PORTS > 8) begin : g_bad_ports
        $error("pcie_cpl_tlp_arb: PORTS must be 2..8");
    end

    if (DATA_WIDTH != TLP_DATA_W || STRB_WIDTH != TLP_STRB_W ||
        HDR_WIDTH != TLP_HDR_W) begin : g_bad_width
        $error("pcie_cpl_tlp_arb: widths must match pcie_tlp_pkg");
    end

    arb_state_e       state_q, state_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]    grant_idx_q, grant_idx_d;
    logic [PORTS-1:0] grant_oh_q, grant_oh_d;
    logic             first_q, first_d;
    logic             proto_err_q, proto_err_d;

    logic [PORTS-1:0] pick_oh;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;

    tlp_beat_t        sel_beat;
    logic             sel_valid;
    logic             busy;
    logic             xfer;

    rr_arb_pick #(
        .PORTS (PORTS),
        .IW    (IW)
    ) u_pick (
        .req     (s_tlp_valid),
        .ptr     (rr_ptr_q),
        .gnt_oh  (pick_oh),
        .gnt_idx (pick_idx),
        .gnt_any (pick_any)
    );

    // Mux the granted source's beat onto a single bundle
    always_comb begin
        sel_beat  = '0;
        sel_valid = 1'b0;
        for (int i = 0; i < PORTS; i++) begin
            if (grant_idx_q == IW'(i)) begin
                sel_beat.data = s_tlp_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_beat.strb = s_tlp_strb[i*STRB_WIDTH +: STRB_WIDTH];
                sel_beat.hdr  = s_tlp_hdr[i*HDR_WIDTH +: HDR_WIDTH];
                sel_beat.sop  = s_tlp_sop[i];
                sel_beat.eop  = s_tlp_eop[i];
                sel_valid     = s_tlp_valid[i];
            end
        end
    end

    assign busy = (state_q == BUSY);
    assign xfer = tx_cpl_tlp_valid && tx_cpl_tlp_ready;

    assign tx_cpl_tlp_data  = sel_beat.data;
    assign tx_cpl_tlp_strb  = sel_beat.strb;
    assign tx_cpl_tlp_hdr   = sel_beat.hdr;
    assign tx_cpl_tlp_sop   = sel_beat.sop;
    assign tx_cpl_tlp_eop   = sel_beat.eop;
    assign tx_cpl_tlp_valid = busy && sel_valid;
    assign s_tlp_ready      = busy ? (grant_oh_q & {PORTS{tx_cpl_tlp_ready}})
                                   : '0;

    assign grant_idx = grant_idx_q;
    assign proto_err = proto_err_q;

    // Arbitrate in IDLE, hold the grant until the EOP beat transfers
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_idx_d = grant_idx_q;
        grant_oh_d  = grant_oh_q;
        first_d     = first_q;
        proto_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d     = BUSY;
                    grant_idx_d = pick_idx;
                    grant_oh_d  = pick_oh;
                    first_d     = 1'b1;
                end
            end
            BUSY: begin
                if (xfer) begin
                    first_d     = 1'b0;
                    proto_err_d = first_q ? !sel_beat.sop : sel_beat.sop;
                    if (sel_beat.eop) begin
                        state_d = IDLE;
                        if (grant_idx_q == IW'(PORTS-1)) begin
                            rr_ptr_d = '0;
                        end else begin
                            rr_ptr_d = grant_idx_q + 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Arbiter state registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            grant_oh_q  <= '0;
            first_q     <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
            grant_oh_q  <= grant_oh_d;
            first_q     <= first_d;
            proto_err_q <= proto_err_d;
        end
    end

endmodule

// File: tb/tb_pcie_cpl_tlp_arb.sv
// Randomized scoreboard bench for pcie_cpl_tlp_arb.
// Sources queue packets; a reference model predicts grant order and framing.
module tb_pcie_cpl_tlp_arb;
    import pcie_tlp_pkg::*;

    localparam int P  = 3;
    localparam int DW = TLP_DATA_W;
    localparam int SW = TLP_STRB_W;
    localparam int HW = TLP_HDR_W;
    localparam int IW = $clog2(P);

    logic            clk = 1'b0;
    logic            rst;
    logic [P*DW-1:0] s_tlp_data;
    logic [P*SW-1:0] s_tlp_strb;
    logic [P*HW-1:0] s_tlp_hdr;
    logic [P-1:0]    s_tlp_valid;
    logic [P-1:0]    s_tlp_sop;
    logic [P-1:0]    s_tlp_eop;
    logic [P-1:0]    s_tlp_ready;
    logic [DW-1:0]   tx_cpl_tlp_data;
    logic [SW-1:0]   tx_cpl_tlp_strb;
    logic [HW-1:0]   tx_cpl_tlp_hdr;
    logic            tx_cpl_tlp_valid;
    logic            tx_cpl_tlp_sop;
    logic            tx_cpl_tlp_eop;
    logic            tx_cpl_tlp_ready;
    logic [IW-1:0]   grant_idx;
    logic            proto_err;

    always #5 clk = ~clk;

    pcie_cpl_tlp_arb #(
        .PORTS      (P),
        .DATA_WIDTH (DW),
        .STRB_WIDTH (SW),
        .HDR_WIDTH  (HW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .s_tlp_data       (s_tlp_data),
        .s_tlp_strb       (s_tlp_strb),
        .s_tlp_hdr        (s_tlp_hdr),
        .s_tlp_valid      (s_tlp_valid),
        .s_tlp_sop        (s_tlp_sop),
        .s_tlp_eop        (s_tlp_eop),
        .s_tlp_ready      (s_tlp_ready),
        .tx_cpl_tlp_data  (tx_cpl_tlp_data),
        .tx_cpl_tlp_strb  (tx_cpl_tlp_strb),
        .tx_cpl_tlp_hdr   (tx_cpl_tlp_hdr),
        .tx_cpl_tlp_valid (tx_cpl_tlp_valid),
        .tx_cpl_tlp_sop   (tx_cpl_tlp_sop),
        .tx_cpl_tlp_eop   (tx_cpl_tlp_eop),
        .tx_cpl_tlp_ready (tx_cpl_tlp_ready),
        .grant_idx        (grant_idx),
        .proto_err        (proto_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    tlp_beat_t src_q[P][$];
    tlp_beat_t exp_q[P][$];
    bit        drv_v[P];
    bit        xfer_flag[P];
    int        gap_pct  = 0;
    int        rdy_pct  = 100;
    bit        in_rst   = 1'b1;
    int        beat_cnt = 0;

    bit m_busy   = 1'b0;
    int m_owner  = 0;
    int m_ptr    = 0;
    bit m_first  = 1'b0;
    bit perr_exp = 1'b0;

    task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int pick(int ptr, logic [P-1:0] v);
        logic [P-1:0] t;
        for (int k = 0; k < P; k++) begin
            t = v >> ((ptr + k) % P);
            if (t[0]) return (ptr + k) % P;
        end
        return -1;
    endfunction

    function automatic bit all_empty();
        for (int i = 0; i < P; i++) begin
            if (src_q[i].size() != 0 || exp_q[i].size() != 0 || drv_v[i])
                return 1'b0;
        end
        return !m_busy;
    endfunction

    task automatic gen_pkt(int p, int n, int corrupt, logic [HW-1:0] hdr);
        tlp_beat_t b;
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < DW / 32; j++) b.data[j*32 +: 32] = $urandom;
            b.strb = SW'($urandom);
            b.hdr  = hdr;
            b.sop  = (k == 0);
            b.eop  = (k == n - 1);
            if (corrupt == 1 && k == 0) b.sop = 1'b0;
            if (corrupt == 2 && k == 1) b.sop = 1'b1;
            src_q[p].push_back(b);
            exp_q[p].push_back(b);
        end
    endtask

    task automatic drain(int budget);
        int c = 0;
        while (c < budget && !all_empty()) begin
            @(negedge clk);
            #1;
            c++;
        end
        chk("drain_done", all_empty(), 1);
        repeat (2) @(negedge clk);
    endtask

    // Source drivers and egress ready, updated just after each rising edge
    always @(posedge clk) begin
        tlp_beat_t b;
        #1;
        for (int i = 0; i < P; i++) begin
            if (xfer_flag[i]) begin
                xfer_flag[i] = 1'b0;
                if (src_q[i].size() > 0) b = src_q[i].pop_front();
                drv_v[i] = 1'b0;
            end
            if (!drv_v[i] && src_q[i].size() > 0 &&
                $urandom_range(99) >= gap_pct)
                drv_v[i] = 1'b1;
            if (drv_v[i]) begin
                b = src_q[i][0];
            end else begin
                for (int j = 0; j < DW / 32; j++) b.data[j*32 +: 32] = $urandom;
                b.strb = SW'($urandom);
                b.hdr  = {$urandom, $urandom, $urandom, $urandom};
                b.sop  = 1'($urandom);
                b.eop  = 1'($urandom);
            end
            s_tlp_data[i*DW +: DW] = b.data;
            s_tlp_strb[i*SW +: SW] = b.strb;
            s_tlp_hdr[i*HW +: HW]  = b.hdr;
            s_tlp_sop[i]           = b.sop;
            s_tlp_eop[i]           = b.eop;
            s_tlp_valid[i]         = drv_v[i];
        end
        tx_cpl_tlp_ready = ($urandom_range(99) < rdy_pct);
    end

    // Reference model and scoreboard, sampled on the falling edge
    always @(negedge clk) begin
        tlp_beat_t    b;
        logic [P-1:0] er;
        logic [P-1:0] sv;
        if (!in_rst) begin
            chk("proto_err", proto_err, perr_exp);
            perr_exp = 1'b0;
            if (!m_busy) begin
                chk("idle_valid", tx_cpl_tlp_valid, 0);
                chk("idle_ready", s_tlp_ready, 0);
                if (|s_tlp_valid) begin
                    m_owner = pick(m_ptr, s_tlp_valid);
                    m_busy  = 1'b1;
                    m_first = 1'b1;
                end
            end else begin
                sv = s_tlp_valid >> m_owner;
                er = '0;
                if (tx_cpl_tlp_ready) er = P'(1) << m_owner;
                chk("fwd_valid", tx_cpl_tlp_valid, sv[0]);
                chk("ready_route", s_tlp_ready, er);
                if (tx_cpl_tlp_valid && tx_cpl_tlp_ready) begin
                    beat_cnt++;
                    if (exp_q[m_owner].size() == 0) begin
                        chk("beat_expected", 0, 1);
                    end else begin
                        b = exp_q[m_owner].pop_front();
                        chk("grant_idx", grant_idx, m_owner);
                        chk("data", tx_cpl_tlp_data, b.data);
                        chk("strb", tx_cpl_tlp_strb, b.strb);
                        chk("hdr", tx_cpl_tlp_hdr, b.hdr);
                        chk("sop", tx_cpl_tlp_sop, b.sop);
                        chk("eop", tx_cpl_tlp_eop, b.eop);
                        perr_exp = m_first ? !b.sop : b.sop;
                        m_first  = 1'b0;
                        if (b.eop) begin
                            m_busy = 1'b0;
                            m_ptr  = (m_owner + 1) % P;
                        end
                    end
                end
            end
            for (int i = 0; i < P; i++)
                xfer_flag[i] = s_tlp_valid[i] && s_tlp_ready[i];
        end
    end

    initial begin
        int c0;
        int len;
        int cor;
        rst              = 1'b1;
        s_tlp_data       = '0;
        s_tlp_strb       = '0;
        s_tlp_hdr        = '0;
        s_tlp_valid      = '0;
        s_tlp_sop        = '0;
        s_tlp_eop        = '0;
        tx_cpl_tlp_ready = 1'b0;
        #2;
        chk("rst_valid", tx_cpl_tlp_valid, 0);
        chk("rst_ready", s_tlp_ready, 0);
        chk("rst_grant", grant_idx, 0);
        chk("rst_perr", proto_err, 0);
        repeat (3) @(posedge clk);
        #2;
        rst    = 1'b0;
        in_rst = 1'b0;

        // single source, 3 beats
        gen_pkt(0, 3, 0, {120'h0, 8'hA5});
        drain(100);
        chk("single_grant", grant_idx, 0);

        // all three ports contend
        gen_pkt(0, 2, 0, {$urandom, $urandom, $urandom, $urandom});
        gen_pkt(1, 2, 0, {$urandom, $urandom, $urandom, $urandom});
        gen_pkt(2, 2, 0, {$urandom, $urandom, $urandom, $urandom});
        drain(100);

        // packet lock: port 0 arrives mid-packet of port 1
        gen_pkt(1, 4, 0, {$urandom, $urandom, $urandom, $urandom});
        repeat (3) @(posedge clk);
        gen_pkt(0, 2, 0, {$urandom, $urandom, $urandom, $urandom});
        drain(100);

        // framing violations under backpressure
        rdy_pct = 50;
        gen_pkt(1, 2, 1, {$urandom, $urandom, $urandom, $urandom});
        gen_pkt(2, 3, 2, {$urandom, $urandom, $urandom, $urandom});
        gen_pkt(0, 1, 1, {$urandom, $urandom, $urandom, $urandom});
        drain(200);

        // random traffic with gaps and backpressure
        gap_pct = 30;
        rdy_pct = 70;
        for (int n = 0; n < 150; n++) begin
            len = $urandom_range(1, 4);
            cor = ($urandom_range(19) == 0) ? $urandom_range(1, 2) : 0;
            if (len == 1 && cor == 2) cor = 1;
            gen_pkt($urandom_range(P - 1), len, cor,
                    {$urandom, $urandom, $urandom, $urandom});
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        drain(20000);

        // park rr_ptr at 2, then reset mid-packet on port 2
        gap_pct = 0;
        rdy_pct = 100;
        gen_pkt(1, 1, 0, {$urandom, $urandom, $urandom, $urandom});
        drain(100);
        gen_pkt(2, 4, 0, {$urandom, $urandom, $urandom, $urandom});
        c0 = beat_cnt;
        for (int k = 0; k < 50 && beat_cnt == c0; k++) begin
            @(negedge clk);
            #1;
        end
        chk("first_beat_seen", beat_cnt > c0, 1);
        @(posedge clk);
        #3;
        chk("beat2_presented", tx_cpl_tlp_valid, 1);
        rst    = 1'b1;
        in_rst = 1'b1;
        #1;
        chk("midrst_valid", tx_cpl_tlp_valid, 0);
        chk("midrst_ready", s_tlp_ready, 0);
        chk("midrst_grant", grant_idx, 0);
        for (int i = 0; i < P; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
            drv_v[i]     = 1'b0;
            xfer_flag[i] = 1'b0;
        end
        s_tlp_valid = '0;
        m_busy      = 1'b0;
        m_ptr       = 0;
        m_first     = 1'b0;
        perr_exp    = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst    = 1'b0;
        in_rst = 1'b0;

        // rr_ptr back at 0: port 1 must beat port 2
        gen_pkt(1, 1, 0, {$urandom, $urandom, $urandom, $urandom});
        gen_pkt(2, 2, 0, {$urandom, $urandom, $urandom, $urandom});
        drain(100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
